// File: rtl/ldo_pkg.sv
// Shared definitions for the LDO power-array path: code width, unit count,
// driver state encoding and the code-to-units mapping used on both sides.
package ldo_pkg;

  localparam int WIDTH = 8;
  localparam int UNITS = 2**WIDTH - 1;

  typedef enum logic [1:0] {
    ST_OFF,
    ST_IDLE,
    ST_RAMP
  } state_t;

  // A code bit of 1 weights a device off, so the enabled-unit count is the complement.
  function automatic logic [WIDTH-1:0] code_to_units(input logic [WIDTH-1:0] code);
    return WIDTH'(UNITS) - code;
  endfunction

endpackage

// File: rtl/therm_decoder.sv
// Binary count to active-low thermometer pattern: unit i is on (0) iff i < count.
module therm_decoder #(
  parameter  int WIDTH = ldo_pkg::WIDTH,
  localparam int UNITS = 2**WIDTH - 1
) (
  input  logic [WIDTH-1:0] count,
  output logic [UNITS-1:0] therm_n
);

  for (genvar i = 0; i < UNITS; i++) begin : g_unit
    assign therm_n[i] = (count <= WIDTH'(i));
  end

endmodule

// File: rtl/pmos_array_driver.sv
// Slew-limited thermometer driver for the PMOS power array: accepts the SAR code,
// ramps the enabled-unit count toward it at most STEP units every DIV cycles.
module pmos_array_driver #(
  parameter  int WIDTH = ldo_pkg::WIDTH,
  parameter  int STEP  = 4,
  parameter  int DIV   = 1,
  localparam int UNITS = 2**WIDTH - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] code_in,
  input  logic             code_vld,
  output logic             code_rdy,
  output logic [UNITS-1:0] gate_n,
  output logic [WIDTH-1:0] on_count,
  output logic             settled,
  output logic             busy
);

  import ldo_pkg::*;

  localparam int             TW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0]  TICK_LAST = TW'(DIV - 1);
  localparam logic [WIDTH:0] STEP_W    = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] UNITS_W = WIDTH'(UNITS);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] target, target_nxt, count_nxt, code_units, stepped;
  logic [TW-1:0]    tick, tick_nxt;
  logic [WIDTH:0]   diff_up, diff_dn, amount;
  logic             accept, ramp_up;
  logic [UNITS-1:0] gate_nxt;

  // One clamped step toward the current target; the extra bit keeps differences unsigned-safe.
  always_comb begin
    code_units = UNITS_W - code_in;
    accept     = code_vld & code_rdy;
    ramp_up    = (on_count < target);
    diff_up    = {1'b0, target} - {1'b0, on_count};
    diff_dn    = {1'b0, on_count} - {1'b0, target};
    if (ramp_up) begin
      amount  = (diff_up > STEP_W) ? STEP_W : diff_up;
      stepped = WIDTH'({1'b0, on_count} + amount);
    end else begin
      amount  = (diff_dn > STEP_W) ? STEP_W : diff_dn;
      stepped = WIDTH'({1'b0, on_count} - amount);
    end
  end

  always_comb begin
    state_nxt  = state;
    count_nxt  = on_count;
    target_nxt = target;
    tick_nxt   = tick;
    if (!en) begin
      state_nxt  = ST_OFF;
      count_nxt  = '0;
      target_nxt = '0;
      tick_nxt   = '0;
    end else begin
      case (state)
        ST_OFF: begin
          state_nxt = ST_IDLE;
        end
        ST_IDLE: begin
          if (accept) begin
            target_nxt = code_units;
            tick_nxt   = '0;
            if (code_units != on_count) state_nxt = ST_RAMP;
          end
        end
        ST_RAMP: begin
          // The step at this edge uses the old target even if a new code lands now.
          if (tick == TICK_LAST) begin
            count_nxt = stepped;
            tick_nxt  = '0;
          end else begin
            tick_nxt = tick + 1'b1;
          end
          if (accept) begin
            target_nxt = code_units;
            tick_nxt   = '0;
          end
          state_nxt = (count_nxt == target_nxt) ? ST_IDLE : ST_RAMP;
        end
        default: begin
          state_nxt  = ST_OFF;
          count_nxt  = '0;
          target_nxt = '0;
          tick_nxt   = '0;
        end
      endcase
    end
  end

  therm_decoder #(.WIDTH(WIDTH)) u_therm (
    .count   (count_nxt),
    .therm_n (gate_nxt)
  );

  // Gate drive is registered from the next count so it moves with on_count glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_OFF;
      on_count <= '0;
      target   <= '0;
      tick     <= '0;
      gate_n   <= '1;
      settled  <= 1'b1;
      busy     <= 1'b0;
      code_rdy <= 1'b0;
    end else begin
      state    <= state_nxt;
      on_count <= count_nxt;
      target   <= target_nxt;
      tick     <= tick_nxt;
      gate_n   <= gate_nxt;
      settled  <= (state_nxt != ST_RAMP);
      busy     <= (state_nxt == ST_RAMP);
      code_rdy <= en;
    end
  end

endmodule

// File: tb/tb_pmos_array_driver.sv
// Directed bench for pmos_array_driver: a STEP=4/DIV=1 instance for the main
// ramps, shutdown and reset, and a STEP=1/DIV=3 instance for the tick divider.
module tb_pmos_array_driver;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en, code_vld, code_rdy, settled, busy;
  logic [7:0]   code_in, on_count;
  logic [254:0] gate_n;
  logic         en_b, code_vld_b, code_rdy_b, settled_b, busy_b;
  logic [7:0]   code_in_b, on_count_b;
  logic [254:0] gate_n_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pmos_array_driver #(.WIDTH(8), .STEP(4), .DIV(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .code_in  (code_in),
    .code_vld (code_vld),
    .code_rdy (code_rdy),
    .gate_n   (gate_n),
    .on_count (on_count),
    .settled  (settled),
    .busy     (busy)
  );

  pmos_array_driver #(.WIDTH(8), .STEP(1), .DIV(3)) dut_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en_b),
    .code_in  (code_in_b),
    .code_vld (code_vld_b),
    .code_rdy (code_rdy_b),
    .gate_n   (gate_n_b),
    .on_count (on_count_b),
    .settled  (settled_b),
    .busy     (busy_b)
  );

  task automatic checkOutput(input string tag, input logic [254:0] obs, input logic [254:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [254:0] expGate(input int n);
    logic [254:0] g;
    for (int i = 0; i < 255; i++) g[i] = (i >= n);
    return g;
  endfunction

  task automatic stepClk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic e, input logic [7:0] c, input logic v);
    en = e; code_in = c; code_vld = v;
    stepClk(1);
  endtask

  task automatic applyStimulusB(input logic e, input logic [7:0] c, input logic v);
    en_b = e; code_in_b = c; code_vld_b = v;
    stepClk(1);
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b0; code_in = 8'h00; code_vld = 1'b0;
    en_b = 1'b0; code_in_b = 8'h00; code_vld_b = 1'b0;
    #12;
    checkOutput("rst_gate", gate_n, {255{1'b1}});
    checkOutput("rst_count", 255'(on_count), 255'(0));
    checkOutput("rst_settled", 255'(settled), 255'(1));
    checkOutput("rst_busy", 255'(busy), 255'(0));
    checkOutput("rst_rdy", 255'(code_rdy), 255'(0));
    rst_n = 1'b1;

    // Ramp 0 -> 128 in 32 steps of 4
    applyStimulus(1'b1, 8'h00, 1'b0);
    checkOutput("rdy_after_en", 255'(code_rdy), 255'(1));
    applyStimulus(1'b1, 8'h7F, 1'b1);
    checkOutput("accept_count", 255'(on_count), 255'(0));
    checkOutput("accept_busy", 255'(busy), 255'(1));
    for (int k = 1; k <= 32; k++) begin
      applyStimulus(1'b1, 8'h00, 1'b0);
      checkOutput($sformatf("ramp128_count_%0d", k), 255'(on_count), 255'(4 * k));
      checkOutput($sformatf("ramp128_settled_%0d", k), 255'(settled), 255'(k == 32));
    end
    checkOutput("gate_128", gate_n, expGate(128));

    // Partial step 128 -> 131
    applyStimulus(1'b1, 8'h7C, 1'b1);
    checkOutput("p3_busy_on", 255'(busy), 255'(1));
    applyStimulus(1'b1, 8'h00, 1'b0);
    checkOutput("p3_count", 255'(on_count), 255'(131));
    checkOutput("p3_busy_off", 255'(busy), 255'(0));
    checkOutput("p3_settled", 255'(settled), 255'(1));

    // Code 0xFF drains the array to zero
    applyStimulus(1'b1, 8'hFF, 1'b1);
    stepClk(32);
    checkOutput("drain_count_32", 255'(on_count), 255'(3));
    applyStimulus(1'b1, 8'h00, 1'b0);
    stepClk(1);
    checkOutput("drain_count", 255'(on_count), 255'(0));
    checkOutput("drain_gate", gate_n, {255{1'b1}});
    checkOutput("drain_settled", 255'(settled), 255'(1));

    // Override toward 16 on the edge that lands on 40
    applyStimulus(1'b1, 8'h7F, 1'b1);
    for (int k = 1; k <= 9; k++) applyStimulus(1'b1, 8'h00, 1'b0);
    checkOutput("ovr_count_36", 255'(on_count), 255'(36));
    applyStimulus(1'b1, 8'hEF, 1'b1);
    checkOutput("ovr_count_40", 255'(on_count), 255'(40));
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(1'b1, 8'h00, 1'b0);
      checkOutput($sformatf("ovr_count_%0d", k), 255'(on_count), 255'(40 - 4 * k));
      checkOutput($sformatf("ovr_settled_%0d", k), 255'(settled), 255'(k == 6));
    end
    applyStimulus(1'b1, 8'h00, 1'b0);
    checkOutput("ovr_hold", 255'(on_count), 255'(16));

    // Ramp to 200 then drop en with a simultaneous code strobe
    applyStimulus(1'b1, 8'h37, 1'b1);
    for (int k = 1; k <= 46; k++) applyStimulus(1'b1, 8'h00, 1'b0);
    checkOutput("r200_count", 255'(on_count), 255'(200));
    checkOutput("r200_gate", gate_n, expGate(200));
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("off_gate", gate_n, {255{1'b1}});
    checkOutput("off_count", 255'(on_count), 255'(0));
    checkOutput("off_rdy", 255'(code_rdy), 255'(0));
    checkOutput("off_settled", 255'(settled), 255'(1));
    checkOutput("off_busy", 255'(busy), 255'(0));
    applyStimulus(1'b0, 8'h10, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("off_vld_count", 255'(on_count), 255'(0));
    applyStimulus(1'b1, 8'h00, 1'b0);
    checkOutput("reen_rdy", 255'(code_rdy), 255'(1));
    applyStimulus(1'b1, 8'h00, 1'b0);
    checkOutput("reen_count", 255'(on_count), 255'(0));
    checkOutput("reen_settled", 255'(settled), 255'(1));

    // Async reset between edges mid-ramp
    applyStimulus(1'b1, 8'h7F, 1'b1);
    for (int k = 1; k <= 5; k++) applyStimulus(1'b1, 8'h00, 1'b0);
    checkOutput("pre_rst_count", 255'(on_count), 255'(20));
    #3 rst_n = 1'b0;
    #1;
    checkOutput("arst_gate", gate_n, {255{1'b1}});
    checkOutput("arst_count", 255'(on_count), 255'(0));
    checkOutput("arst_busy", 255'(busy), 255'(0));
    checkOutput("arst_settled", 255'(settled), 255'(1));
    checkOutput("arst_rdy", 255'(code_rdy), 255'(0));
    @(posedge clk);
    #3 rst_n = 1'b1;
    stepClk(1);
    checkOutput("post_rst_rdy", 255'(code_rdy), 255'(1));
    stepClk(3);
    checkOutput("post_rst_count", 255'(on_count), 255'(0));
    checkOutput("post_rst_settled", 255'(settled), 255'(1));

    // Code 0x00 fills all 255 units, last step partial
    applyStimulus(1'b1, 8'h00, 1'b1);
    for (int k = 1; k <= 64; k++) begin
      applyStimulus(1'b1, 8'h00, 1'b0);
      if (k == 63) checkOutput("full_count_63", 255'(on_count), 255'(252));
    end
    checkOutput("full_count", 255'(on_count), 255'(255));
    checkOutput("full_gate", gate_n, 255'(0));
    checkOutput("full_settled", 255'(settled), 255'(1));

    // Divided tick: STEP=1, DIV=3, target 5
    applyStimulusB(1'b1, 8'h00, 1'b0);
    applyStimulusB(1'b1, 8'hFA, 1'b1);
    checkOutput("div_accept_busy", 255'(busy_b), 255'(1));
    for (int k = 1; k <= 15; k++) begin
      applyStimulusB(1'b1, 8'h00, 1'b0);
      checkOutput($sformatf("div_count_%0d", k), 255'(on_count_b), 255'(k / 3));
      checkOutput($sformatf("div_settled_%0d", k), 255'(settled_b), 255'(k == 15));
    end
    checkOutput("div_gate", gate_n_b, expGate(5));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
